// File: rtl/sobel_edge_filter_if.sv
// sobel_edge_filter_if: 3x3 RGB565 window in, filtered pixel plus delayed sync qualifiers out.
interface sobel_edge_filter_if;
  logic        de_in;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic [1:0]  mode;
  logic [15:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic [15:0] pixel_out;
  logic        edge_out;
  logic [7:0]  mag_out;
  logic        de_out;
  logic [9:0]  x_out;
  logic [9:0]  y_out;
  modport master (
    output de_in, x_pixel, y_pixel, mode, p00, p01, p02, p10, p11, p12, p20, p21, p22,
    input  pixel_out, edge_out, mag_out, de_out, x_out, y_out
  );
  modport slave (
    input  de_in, x_pixel, y_pixel, mode, p00, p01, p02, p10, p11, p12, p20, p21, p22,
    output pixel_out, edge_out, mag_out, de_out, x_out, y_out
  );
endinterface

// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter: 3-stage luminance -> Sobel gradient -> magnitude/threshold pipeline, one pixel per clock.
module sobel_edge_filter #(
  parameter logic [7:0] THRESHOLD = 8'd100,
  parameter logic [9:0] X_MAX     = 10'd639,
  parameter logic [9:0] Y_MAX     = 10'd479
) (
  input logic clk,
  input logic reset_n,
  sobel_edge_filter_if.slave bus
);
  function automatic logic [7:0] luma(input logic [15:0] p);
    logic [15:0] s;
    s = 16'd77 * {8'd0, p[15:11], p[15:13]} + 16'd150 * {8'd0, p[10:5], p[10:9]}
      + 16'd29 * {8'd0, p[4:0], p[4:2]};
    return s[15:8];
  endfunction
  function automatic logic signed [10:0] ext(input logic [7:0] v);
    return {3'b000, v};
  endfunction
  function automatic logic [15:0] rep(input logic [7:0] v);
    return {v[7:3], v[7:2], v[7:3]};
  endfunction
  logic [15:0] win [9];
  assign win[0] = bus.p00;
  assign win[1] = bus.p01;
  assign win[2] = bus.p02;
  assign win[3] = bus.p10;
  assign win[4] = bus.p11;
  assign win[5] = bus.p12;
  assign win[6] = bus.p20;
  assign win[7] = bus.p21;
  assign win[8] = bus.p22;
  logic [7:0]  g [9];
  logic        de1, de2;
  logic [9:0]  x1, y1, x2, y2;
  logic [1:0]  mode1, mode2;
  logic [15:0] p1, p2;
  logic [7:0]  g11_2;
  logic signed [10:0] gx, gy, gx_c, gy_c;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) g[i] <= '0;
      de1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      mode1 <= '0;
      p1 <= '0;
    end else begin
      for (int i = 0; i < 9; i++) g[i] <= luma(win[i]);
      de1 <= bus.de_in;
      x1 <= bus.x_pixel;
      y1 <= bus.y_pixel;
      mode1 <= bus.mode;
      p1 <= bus.p11;
    end
  assign gx_c = (ext(g[2]) + (ext(g[5]) <<< 1) + ext(g[8])) - (ext(g[0]) + (ext(g[3]) <<< 1) + ext(g[6]));
  assign gy_c = (ext(g[6]) + (ext(g[7]) <<< 1) + ext(g[8])) - (ext(g[0]) + (ext(g[1]) <<< 1) + ext(g[2]));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      gx <= '0;
      gy <= '0;
      g11_2 <= '0;
      de2 <= 1'b0;
      x2 <= '0;
      y2 <= '0;
      mode2 <= '0;
      p2 <= '0;
    end else begin
      gx <= gx_c;
      gy <= gy_c;
      g11_2 <= g[4];
      de2 <= de1;
      x2 <= x1;
      y2 <= y1;
      mode2 <= mode1;
      p2 <= p1;
    end
  logic [10:0] ax, ay;
  logic [11:0] sum;
  logic [7:0]  mag;
  logic        edge_c;
  logic [15:0] pix;
  always_comb begin
    ax = gx[10] ? 11'(-gx) : gx;
    ay = gy[10] ? 11'(-gy) : gy;
    sum = {1'b0, ax} + {1'b0, ay};
    mag = |sum[11:8] ? 8'hFF : sum[7:0];
    edge_c = mag >= THRESHOLD;
    pix = mode2 == 2'd0 ? rep(g11_2) : mode2 == 2'd1 ? rep(mag) : mode2 == 2'd2 ? {16{edge_c}} : p2;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.pixel_out <= '0;
      bus.edge_out <= 1'b0;
      bus.mag_out <= '0;
      bus.de_out <= 1'b0;
      bus.x_out <= '0;
      bus.y_out <= '0;
    end else begin
      bus.pixel_out <= de2 ? pix : 16'h0000;
      bus.edge_out <= de2 & edge_c;
      bus.mag_out <= de2 ? mag : 8'h00;
      bus.de_out <= de2;
      bus.x_out <= x2 > X_MAX ? X_MAX : x2;
      bus.y_out <= y2 > Y_MAX ? Y_MAX : y2;
    end
endmodule
